hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage CPU.
- Generates stall/flush for the IF/ID, ID/EX and EX/MEM registers and selects the next-PC source.
- Resolves load-use hazards, branch mispredicts, MRET, WFI sleep and interrupt entry.
- All state advances only on a global-advance cycle (IF_DONE && MEM_DONE), matching the pipeline registers it drives.

Parameters:
- PERF_W, 32, width of the stall and flush performance counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- IF_DONE  in  1  instruction fetch complete this cycle
- MEM_DONE  in  1  data memory access complete this cycle
- ID_rs1  in  5  decode-stage rs1 index
- ID_rs2  in  5  decode-stage rs2 index
- ID_use_rs1  in  1  decode instruction reads rs1
- ID_use_rs2  in  1  decode instruction reads rs2
- EX_op  in  5  execute-stage opcode (inst[6:2])
- EX_rd  in  5  execute-stage destination
- EX_pc  in  32  execute-stage PC
- EX_mispredict  in  1  branch/jump outcome differs from prediction
- EX_WFI  in  1  WFI in execute
- EX_MRET  in  1  MRET in execute
- irq_pending  in  1  any enabled-source interrupt pending (mip & mie != 0)
- irq_en  in  1  mstatus.MIE
- IFID_stall  out  1  hold IF/ID
- IFID_flush  out  1  bubble IF/ID
- IDEX_stall  out  1  hold ID/EX
- IDEX_flush  out  1  bubble ID/EX
- EXMEM_flush  out  1  bubble EX/MEM
- pc_sel  out  2  next-PC select (pc_sel_e)
- resume_pc  out  32  PC used when pc_sel == PC_RESUME
- trap_take  out  1  one-cycle trap-entry strobe to CSR unit
- trap_epc  out  32  mepc value for trap_take
- wfi_sleep  out  1  core sleeping in WFI
- stall_cnt  out  PERF_W  load-use stall cycles
- flush_cnt  out  PERF_W  flush events

Behaviour:
- adv = IF_DONE && MEM_DONE. State, resume_pc and counters change only when adv = 1. Outputs are combinational from state and inputs.
- Reset: state = RUN, resume_pc = 0, counters = 0.
- Reset values of outputs (with inputs idle): stalls and flushes 0, pc_sel = PC_SEQ, trap_take = 0, wfi_sleep = 0, trap_epc = 0.
- ex_valid = (EX_op != BUBBLE_OPCODE).
- load_use = EX_op ∈ {OP_LOAD, OP_FLOAD} && EX_rd != 0 && ((ID_use_rs1 && ID_rs1 == EX_rd) || (ID_use_rs2 && ID_rs2 == EX_rd)).
- States: RUN, SLEEP, WAKE.
- RUN priority (highest first):
  1. irq_pending && irq_en && ex_valid && !EX_mispredict: trap. All three flushes = 1, pc_sel = PC_TRAP, trap_take = 1, trap_epc = EX_pc. The EX instruction is squashed and re-executed after MRET.
  2. EX_mispredict: IFID_flush = IDEX_flush = 1, pc_sel = PC_BRANCH.
  3. EX_MRET: IFID_flush = IDEX_flush = 1, pc_sel = PC_MRET.
  4. EX_WFI: IFID_flush = IDEX_flush = 1. On adv: resume_pc <= EX_pc + 4 (mod 2^32), go to SLEEP.
  5. load_use: IFID_stall = 1, IDEX_flush = 1. On adv: stall_cnt += 1.
  6. Otherwise: all stall/flush outputs 0, pc_sel = PC_SEQ.
- SLEEP: wfi_sleep = 1, IFID_flush = IDEX_flush = 1, pc_sel = PC_HOLD. On adv with irq_pending, go to WAKE. Wake-up does not depend on irq_en.
- WAKE, for one adv cycle:
  - irq_en = 1: trap_take = 1, trap_epc = resume_pc, pc_sel = PC_TRAP, all flushes = 1.
  - irq_en = 0: pc_sel = PC_RESUME.
  - Either way, go to RUN.
- flush_cnt += 1 on every adv cycle in which any of rules 1–4 or WAKE fires. It counts events, not flushed registers.
- Counters wrap at 2^PERF_W.
- !adv: outputs still reflect the current decision. The pipeline registers ignore them. trap_take is qualified by adv downstream. The state machine holds.
- Reset mid-SLEEP returns to RUN immediately, asynchronously.

Decomposition:
- cpu_pkg holds: BUBBLE_OPCODE, OP_LOAD = 5'b00000, OP_FLOAD = 5'b00001, and the enum pc_sel_e {PC_SEQ, PC_BRANCH, PC_TRAP, PC_MRET, PC_RESUME, PC_HOLD}.
- PC_HOLD and PC_RESUME need pc_sel widened to 3 bits; the pc_sel port is therefore 3 bits wide.
- One sub-module, hazard_perf_cnt: the two saturating-free counters with the adv enable.

Test Plan:
- Load-use: EX_op = OP_LOAD, EX_rd = 5, ID_rs1 = 5, ID_use_rs1 = 1, adv = 1 -> IFID_stall = 1, IDEX_flush = 1, stall_cnt 0→1. Same case with EX_rd = 0 -> no stall.
- Mispredict and load_use together -> flushes only, pc_sel = PC_BRANCH, stall_cnt unchanged, flush_cnt += 1.
- Handshake hold: load_use with IF_DONE = 0 for 3 cycles, then 1 -> stall_cnt increments exactly once.
- WFI: EX_WFI, EX_pc = 0x100 -> SLEEP, wfi_sleep = 1. irq_pending with irq_en = 0 -> WAKE, pc_sel = PC_RESUME, resume_pc = 0x104, then RUN.
- Interrupt: RUN, ex_valid, EX_pc = 0x200, irq_pending = irq_en = 1 -> trap_take = 1, trap_epc = 0x200, all flushes = 1. With EX_op = BUBBLE_OPCODE -> no trap.
- Async reset: assert rst_n = 0 while in SLEEP mid-cycle -> wfi_sleep = 0 and counters = 0 immediately.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared opcodes, next-PC select and sequencer state types
package hazard_ctrl_pkg;

  // Opcode field (inst[6:2]) the pipeline inserts for an empty slot; reserved in RV32.
  localparam logic [4:0] BUBBLE_OPCODE = 5'b11111;
  localparam logic [4:0] OP_LOAD       = 5'b00000;
  localparam logic [4:0] OP_FLOAD      = 5'b00001;

  typedef enum logic [2:0] {
    PC_SEQ    = 3'd0,
    PC_BRANCH = 3'd1,
    PC_TRAP   = 3'd2,
    PC_MRET   = 3'd3,
    PC_RESUME = 3'd4,
    PC_HOLD   = 3'd5
  } pc_sel_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SLEEP = 2'd1,
    ST_WAKE  = 2'd2
  } hz_state_e;

  // A load in EX whose non-x0 destination is read by the instruction in ID.
  function automatic logic is_load_use(
    input logic [4:0] ex_op,
    input logic [4:0] ex_rd,
    input logic [4:0] id_rs1,
    input logic [4:0] id_rs2,
    input logic       use_rs1,
    input logic       use_rs2
  );
    logic is_load;
    is_load = (ex_op == OP_LOAD) || (ex_op == OP_FLOAD);
    return is_load && (ex_rd != 5'd0) &&
           ((use_rs1 && (id_rs1 == ex_rd)) || (use_rs2 && (id_rs2 == ex_rd)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-status inputs and sequencing outputs of the hazard controller
interface hazard_ctrl_if #(
  parameter int PERF_W = 32
);
  import hazard_ctrl_pkg::*;

  logic              IF_DONE;
  logic              MEM_DONE;
  logic [4:0]        ID_rs1;
  logic [4:0]        ID_rs2;
  logic              ID_use_rs1;
  logic              ID_use_rs2;
  logic [4:0]        EX_op;
  logic [4:0]        EX_rd;
  logic [31:0]       EX_pc;
  logic              EX_mispredict;
  logic              EX_WFI;
  logic              EX_MRET;
  logic              irq_pending;
  logic              irq_en;

  logic              IFID_stall;
  logic              IFID_flush;
  logic              IDEX_stall;
  logic              IDEX_flush;
  logic              EXMEM_flush;
  pc_sel_e           pc_sel;
  logic [31:0]       resume_pc;
  logic              trap_take;
  logic [31:0]       trap_epc;
  logic              wfi_sleep;
  logic [PERF_W-1:0] stall_cnt;
  logic [PERF_W-1:0] flush_cnt;

  modport slave (
    input  IF_DONE, MEM_DONE, ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2,
    input  EX_op, EX_rd, EX_pc, EX_mispredict, EX_WFI, EX_MRET, irq_pending, irq_en,
    output IFID_stall, IFID_flush, IDEX_stall, IDEX_flush, EXMEM_flush,
    output pc_sel, resume_pc, trap_take, trap_epc, wfi_sleep, stall_cnt, flush_cnt
  );

  modport master (
    output IF_DONE, MEM_DONE, ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2,
    output EX_op, EX_rd, EX_pc, EX_mispredict, EX_WFI, EX_MRET, irq_pending, irq_en,
    input  IFID_stall, IFID_flush, IDEX_stall, IDEX_flush, EXMEM_flush,
    input  pc_sel, resume_pc, trap_take, trap_epc, wfi_sleep, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_ctrl_perf_cnt.sv
// rtl/hazard_ctrl_perf_cnt.sv - wrapping load-use stall and flush-event counters
module hazard_perf_cnt #(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_adv,
  input  logic              i_stall_inc,
  input  logic              i_flush_inc,
  output logic [PERF_W-1:0] o_stall_cnt,
  output logic [PERF_W-1:0] o_flush_cnt
);

  localparam logic [PERF_W-1:0] ONE = {{(PERF_W-1){1'b0}}, 1'b1};

  logic [PERF_W-1:0] r_stall_cnt;
  logic [PERF_W-1:0] r_flush_cnt;

  // Count one load-use bubble per global-advance cycle; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (i_adv && i_stall_inc) begin
      r_stall_cnt <= r_stall_cnt + ONE;
    end
  end

  // Count one redirect/flush event per global-advance cycle; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush_cnt <= '0;
    end else if (i_adv && i_flush_inc) begin
      r_flush_cnt <= r_flush_cnt + ONE;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush and next-PC sequencer with WFI sleep and trap entry
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int PERF_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave bus
);

  hz_state_e   r_state;
  hz_state_e   w_state_nxt;
  logic [31:0] r_resume_pc;
  logic [31:0] w_resume_nxt;

  logic        w_adv;
  logic        w_ex_valid;
  logic        w_load_use;
  logic        w_irq_trap;

  logic        w_ifid_stall;
  logic        w_ifid_flush;
  logic        w_idex_flush;
  logic        w_exmem_flush;
  pc_sel_e     w_pc_sel;
  logic        w_trap_take;
  logic [31:0] w_trap_epc;
  logic        w_wfi_sleep;
  logic        w_stall_inc;
  logic        w_flush_inc;

  assign w_adv      = bus.IF_DONE && bus.MEM_DONE;
  assign w_ex_valid = (bus.EX_op != BUBBLE_OPCODE);
  assign w_load_use = is_load_use(bus.EX_op, bus.EX_rd, bus.ID_rs1, bus.ID_rs2,
                                  bus.ID_use_rs1, bus.ID_use_rs2);
  // A mispredicting instruction is redirected, not trapped, so the branch target wins.
  assign w_irq_trap = bus.irq_pending && bus.irq_en && w_ex_valid && !bus.EX_mispredict;

  // Sequencer state and wake-up PC move only together with the pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_resume_pc <= '0;
    end else if (w_adv) begin
      r_state     <= w_state_nxt;
      r_resume_pc <= w_resume_nxt;
    end
  end

  // Priority decision for this cycle; outputs are valid even when the pipe is not advancing.
  always_comb begin
    w_state_nxt   = r_state;
    w_resume_nxt  = r_resume_pc;
    w_ifid_stall  = 1'b0;
    w_ifid_flush  = 1'b0;
    w_idex_flush  = 1'b0;
    w_exmem_flush = 1'b0;
    w_pc_sel      = PC_SEQ;
    w_trap_take   = 1'b0;
    w_trap_epc    = '0;
    w_wfi_sleep   = 1'b0;
    w_stall_inc   = 1'b0;
    w_flush_inc   = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_irq_trap) begin
          w_ifid_flush  = 1'b1;
          w_idex_flush  = 1'b1;
          w_exmem_flush = 1'b1;
          w_pc_sel      = PC_TRAP;
          w_trap_take   = 1'b1;
          w_trap_epc    = bus.EX_pc;
          w_flush_inc   = 1'b1;
        end else if (bus.EX_mispredict) begin
          w_ifid_flush = 1'b1;
          w_idex_flush = 1'b1;
          w_pc_sel     = PC_BRANCH;
          w_flush_inc  = 1'b1;
        end else if (bus.EX_MRET) begin
          w_ifid_flush = 1'b1;
          w_idex_flush = 1'b1;
          w_pc_sel     = PC_MRET;
          w_flush_inc  = 1'b1;
        end else if (bus.EX_WFI) begin
          w_ifid_flush = 1'b1;
          w_idex_flush = 1'b1;
          w_flush_inc  = 1'b1;
          w_resume_nxt = bus.EX_pc + 32'd4;
          w_state_nxt  = ST_SLEEP;
        end else if (w_load_use) begin
          w_ifid_stall = 1'b1;
          w_idex_flush = 1'b1;
          w_stall_inc  = 1'b1;
        end
      end
      ST_SLEEP: begin
        w_wfi_sleep  = 1'b1;
        w_ifid_flush = 1'b1;
        w_idex_flush = 1'b1;
        w_pc_sel     = PC_HOLD;
        if (bus.irq_pending) begin
          w_state_nxt = ST_WAKE;
        end
      end
      ST_WAKE: begin
        w_flush_inc = 1'b1;
        w_state_nxt = ST_RUN;
        if (bus.irq_en) begin
          w_ifid_flush  = 1'b1;
          w_idex_flush  = 1'b1;
          w_exmem_flush = 1'b1;
          w_pc_sel      = PC_TRAP;
          w_trap_take   = 1'b1;
          w_trap_epc    = r_resume_pc;
        end else begin
          w_pc_sel = PC_RESUME;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  hazard_perf_cnt #(
    .PERF_W (PERF_W)
  ) u_perf_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_adv       (w_adv),
    .i_stall_inc (w_stall_inc),
    .i_flush_inc (w_flush_inc),
    .o_stall_cnt (bus.stall_cnt),
    .o_flush_cnt (bus.flush_cnt)
  );

  assign bus.IFID_stall  = w_ifid_stall;
  assign bus.IFID_flush  = w_ifid_flush;
  assign bus.IDEX_stall  = 1'b0;
  assign bus.IDEX_flush  = w_idex_flush;
  assign bus.EXMEM_flush = w_exmem_flush;
  assign bus.pc_sel      = w_pc_sel;
  assign bus.resume_pc   = r_resume_pc;
  assign bus.trap_take   = w_trap_take;
  assign bus.trap_epc    = w_trap_epc;
  assign bus.wfi_sleep   = w_wfi_sleep;

endmodule
